// File: rtl/parity_assembler_if.sv
// Byte-stream input and recovered-word output bundle for parity_assembler.
// master = upstream serializer/consumer side, slave = the assembler itself.
interface parity_assembler_if;
    logic [8:0]  S_in;
    logic        val_in;
    logic        done_in;
    logic [31:0] A_out;
    logic        valid;
    logic        perr;
    logic [3:0]  err_mask;
    logic        ferr;
    logic [2:0]  estado;

    modport master (
        output S_in, val_in, done_in,
        input  A_out, valid, perr, err_mask, ferr, estado
    );

    modport slave (
        input  S_in, val_in, done_in,
        output A_out, valid, perr, err_mask, ferr, estado
    );
endinterface

// File: rtl/parity_assembler.sv
// Reassembles four 9-bit parity-tagged bytes (MSB first) into a 32-bit word, flagging
// parity and framing errors. Parity checking is built only when PARITY_CHECK_EN is defined.
module parity_assembler (
    input  logic              clk,
    input  logic              rst,
    parity_assembler_if.slave bus
);
    typedef enum logic [1:0] {
        W0 = 2'd0,
        W1 = 2'd1,
        W2 = 2'd2,
        W3 = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        capture;
    logic        deliver;
    logic        ferr_d;
    logic [31:0] a_q;
    logic        valid_q;
    logic        ferr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= W0;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        deliver = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            W0: begin
                if (bus.val_in) begin
                    if (bus.done_in) begin
                        ferr_d = 1'b1;
                    end else begin
                        capture = 1'b1;
                        state_d = W1;
                    end
                end
            end
            W1, W2: begin
                if (bus.val_in && !bus.done_in) begin
                    capture = 1'b1;
                    state_d = (state_q == W1) ? W2 : W3;
                end else begin
                    // early done or a gap both abandon the partial frame
                    ferr_d  = 1'b1;
                    state_d = W0;
                end
            end
            W3: begin
                state_d = W0;
                if (bus.val_in) begin
                    deliver = 1'b1;
                    ferr_d  = !bus.done_in;
                end else begin
                    ferr_d  = 1'b1;
                end
            end
            default: state_d = W0;
        endcase
    end

    // Lanes 3..1 hold bytes 0..2 of the frame in progress; lane 0 is taken straight from S_in.
    generate
        for (genvar gi = 1; gi <= 3; gi++) begin : lanes
            localparam logic [1:0] LANE_ST = 2'(3 - gi);
            logic [7:0] lane_q;
            logic       bad_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    lane_q <= 8'h00;
                    bad_q  <= 1'b0;
                end else if (capture && (state_q == LANE_ST)) begin
                    lane_q <= bus.S_in[7:0];
`ifdef PARITY_CHECK_EN
                    bad_q  <= ^bus.S_in;
`else
                    bad_q  <= 1'b0;
`endif
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q     <= 32'h0000_0000;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= deliver;
            ferr_q  <= ferr_d;
            if (deliver)
                a_q <= {lanes[3].lane_q, lanes[2].lane_q, lanes[1].lane_q, bus.S_in[7:0]};
        end
    end

`ifdef PARITY_CHECK_EN
    logic [3:0] mask_q;
    logic [3:0] mask_d;
    logic       perr_q;

    assign mask_d = {lanes[3].bad_q, lanes[2].bad_q, lanes[1].bad_q, ^bus.S_in};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q <= 4'b0000;
            perr_q <= 1'b0;
        end else begin
            perr_q <= deliver && (|mask_d);
            if (deliver)
                mask_q <= mask_d;
        end
    end

    assign bus.perr     = perr_q;
    assign bus.err_mask = mask_q;
`else
    logic unused_parity_bits;
    assign unused_parity_bits = bus.S_in[8] | lanes[3].bad_q | lanes[2].bad_q | lanes[1].bad_q;

    assign bus.perr     = 1'b0;
    assign bus.err_mask = 4'b0000;
`endif

    assign bus.A_out  = a_q;
    assign bus.valid  = valid_q;
    assign bus.ferr   = ferr_q;
    assign bus.estado = {1'b0, state_q};
endmodule

// File: tb/tb_parity_assembler.sv
// Scoreboard bench for parity_assembler: directed frames then random byte streams,
// with expected output events produced by a frame-list reference model.
module tb_parity_assembler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    parity_assembler_if bus ();
    parity_assembler dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit          v;
        bit          f;
        logic [31:0] a;
        logic [3:0]  m;
        bit          p;
    } ev_t;

    ev_t         exp_q[$];
    logic [8:0]  frame[$];
    logic [31:0] last_a = 32'h0;
    logic [3:0]  last_m = 4'h0;
    int          n_cmp  = 0;
    int          n_bad  = 0;
    ev_t         mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_ferr();
        ev_t e;
        e.v = 1'b0; e.f = 1'b1; e.a = last_a; e.m = last_m; e.p = 1'b0;
        exp_q.push_back(e);
    endfunction

    // Reference: collect bytes of the current frame; four bytes make a word, anything else is a framing fault.
    function automatic void model_step(input bit v, input bit d, input logic [8:0] b);
        ev_t e;
        if (!v) begin
            if (frame.size() > 0) begin
                push_ferr();
                frame.delete();
            end
        end else begin
            frame.push_back(b);
            if (frame.size() == 4) begin
                e.a = {frame[0][7:0], frame[1][7:0], frame[2][7:0], frame[3][7:0]};
                e.m = 4'b0000;
`ifdef PARITY_CHECK_EN
                for (int i = 0; i < 4; i++)
                    e.m[3-i] = ($countones(frame[i]) % 2) == 1;
`endif
                e.v = 1'b1;
                e.f = !d;
                e.p = (e.m != 4'b0000);
                last_a = e.a;
                last_m = e.m;
                exp_q.push_back(e);
                frame.delete();
            end else if (d) begin
                push_ferr();
                frame.delete();
            end
        end
    endfunction

    task automatic drive(input bit v, input bit d, input logic [8:0] b);
        bus.val_in  = v;
        bus.done_in = d;
        bus.S_in    = b;
        model_step(v, d, b);
        @(posedge clk);
        #1;
        check("estado", {29'd0, bus.estado}, frame.size());
    endtask

    task automatic frame4(input logic [8:0] b0, b1, b2, b3);
        drive(1'b1, 1'b0, b0);
        drive(1'b1, 1'b0, b1);
        drive(1'b1, 1'b0, b2);
        drive(1'b1, 1'b1, b3);
    endtask

    task automatic check_reset_outputs();
        check("rst_A_out",    bus.A_out,            32'h0);
        check("rst_valid",    {31'd0, bus.valid},   32'h0);
        check("rst_perr",     {31'd0, bus.perr},    32'h0);
        check("rst_err_mask", {28'd0, bus.err_mask}, 32'h0);
        check("rst_ferr",     {31'd0, bus.ferr},    32'h0);
        check("rst_estado",   {29'd0, bus.estado},  32'h0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.valid || bus.ferr) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: valid=%b ferr=%b A_out=%h expected no event", bus.valid, bus.ferr, bus.A_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("valid",    {31'd0, bus.valid},    {31'd0, mon_e.v});
                    check("ferr",     {31'd0, bus.ferr},     {31'd0, mon_e.f});
                    check("A_out",    bus.A_out,             mon_e.a);
                    check("err_mask", {28'd0, bus.err_mask}, {28'd0, mon_e.m});
                    check("perr",     {31'd0, bus.perr},     {31'd0, mon_e.p});
                    $display("event t=%0t valid=%b ferr=%b A_out=%h err_mask=%b perr=%b",
                             $time, bus.valid, bus.ferr, bus.A_out, bus.err_mask, bus.perr);
                end
            end else begin
                check("perr_idle", {31'd0, bus.perr}, 32'h0);
            end
        end
    end

    initial begin
        bus.val_in  = 1'b0;
        bus.done_in = 1'b0;
        bus.S_in    = 9'h000;
        #12;
        check_reset_outputs();
        rst = 1'b1;
        @(posedge clk);
        #1;

        frame4(9'h0DE, 9'h1AD, 9'h0BE, 9'h1EF);          // good frame
        drive(1'b0, 1'b0, 9'h000);
        frame4(9'h0DE, 9'h0AD, 9'h0BE, 9'h1EF);          // parity error on byte 1
        drive(1'b0, 1'b0, 9'h000);
        drive(1'b1, 1'b0, 9'h0DE);                        // gap mid-frame
        drive(1'b1, 1'b0, 9'h1AD);
        drive(1'b0, 1'b0, 9'h000);
        drive(1'b0, 1'b0, 9'h000);
        drive(1'b1, 1'b1, 9'h0DE);                        // early done
        frame4(9'h0DE, 9'h1AD, 9'h0BE, 9'h1EF);
        frame4(9'h101, 9'h102, 9'h003, 9'h104);           // back-to-back
        frame4(9'h0DE, 9'h1AD, 9'h0BE, 9'h1EF);
        drive(1'b1, 1'b0, 9'h012);                        // missing done on byte 3
        drive(1'b1, 1'b0, 9'h134);
        drive(1'b1, 1'b0, 9'h056);
        drive(1'b1, 1'b0, 9'h178);
        drive(1'b0, 1'b0, 9'h000);

        drive(1'b1, 1'b0, 9'h0DE);                        // reset mid-frame
        drive(1'b1, 1'b0, 9'h1AD);
        bus.val_in = 1'b0;
        rst = 1'b0;
        frame.delete();
        last_a = 32'h0;
        last_m = 4'h0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        frame4(9'h0DE, 9'h1AD, 9'h0BE, 9'h1EF);
        drive(1'b0, 1'b0, 9'h000);

        for (int c = 0; c < 3000; c++) begin
            bit          v, d;
            logic [7:0]  data;
            logic        par;
            v    = ($urandom_range(0, 15) != 0);
            d    = (frame.size() == 3) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 19) == 0);
            data = 8'($urandom);
            par  = ^data;
            if ($urandom_range(0, 4) == 0) par = ~par;
            drive(v, d, {par, data});
        end
        drive(1'b0, 1'b0, 9'h000);
        drive(1'b0, 1'b0, 9'h000);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
